// File: rtl/icache_pkg.sv
// Shared fetch/CBus types, bus encodings and instruction-cache types.
package icache_pkg;

  localparam logic [63:0] MMIO_BOUND = 64'h8000_0000;

  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;
  typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1} mburst_t;

  // Burst length is encoded as beats-1.
  typedef logic [7:0] mlen_t;
  localparam mlen_t MLEN1 = 8'd0;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    mburst_t     burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  // Tag is the address shifted down past index and offset; unused upper bits trim away.
  typedef logic [63:0] icache_tag_t;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_UNCACHED} icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: one combinational read port, one whole-line write port, clear-all.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned IDX_W          = $clog2(NUM_LINES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [IDX_W-1:0]               rd_idx_i,
  output logic                           rd_valid_o,
  output icache_tag_t                    rd_tag_o,
  output logic [WORDS_PER_LINE-1:0][63:0] rd_line_o,
  input  logic                           wr_en_i,
  input  logic [IDX_W-1:0]               wr_idx_i,
  input  icache_tag_t                    wr_tag_i,
  input  logic [WORDS_PER_LINE-1:0][63:0] wr_line_i,
  input  logic                           clr_i
);

  logic [NUM_LINES-1:0]            valid_q;
  icache_tag_t                     tag_q  [NUM_LINES];
  logic [WORDS_PER_LINE-1:0][63:0] data_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  // Clear wins over a simultaneous fill so a flush during refill also drops the new line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, burst line refill, uncached MMIO bypass.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  input  logic       flush
);

  localparam int unsigned CNT_W    = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W    = $clog2(NUM_LINES);
  localparam int unsigned LINE_LSB = 3 + CNT_W;
  localparam int unsigned TAG_LSB  = LINE_LSB + IDX_W;
  localparam logic [63:0] LINE_MASK = ~((64'd1 << LINE_LSB) - 64'd1);

  typedef logic [WORDS_PER_LINE-1:0][63:0] line_t;

  icache_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fpend_q, fpend_d;
  logic             upend_q, upend_d;
  logic [63:0]      addr_q, addr_d;
  logic [31:0]      udata_q, udata_d;
  line_t            linebuf_q, wr_line, rd_line;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  icache_tag_t      rd_tag, req_tag, wr_tag;
  logic             rd_valid, wr_en, clr, hit, uncached;
  logic [63:0]      rd_word;

  assign rd_idx   = ireq.addr[LINE_LSB +: IDX_W];
  assign req_tag  = icache_tag_t'(ireq.addr >> TAG_LSB);
  assign wr_idx   = addr_q[LINE_LSB +: IDX_W];
  assign wr_tag   = icache_tag_t'(addr_q >> TAG_LSB);
  assign rd_word  = rd_line[ireq.addr[3 +: CNT_W]];
  assign uncached = ireq.addr < MMIO_BOUND;
  assign hit      = rd_valid && (rd_tag == req_tag);

  icache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (rd_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx),
    .wr_tag_i   (wr_tag),
    .wr_line_i  (wr_line),
    .clr_i      (clr)
  );

  // The final beat goes straight into the array alongside the buffered earlier beats.
  always_comb begin
    wr_line        = linebuf_q;
    wr_line[cnt_q] = cresp.data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fpend_d = fpend_q | (flush && (state_q != S_IDLE));
    upend_d = 1'b0;
    addr_d  = addr_q;
    udata_d = udata_q;
    wr_en   = 1'b0;
    clr     = 1'b0;
    iresp   = '0;
    creq    = '0;
    unique case (state_q)
      S_IDLE: begin
        clr = flush;
        if (upend_q) begin
          iresp.addr_ok = 1'b1;
          iresp.data_ok = 1'b1;
          iresp.data    = udata_q;
        end else if (ireq.valid) begin
          if (uncached) begin
            state_d = S_UNCACHED;
            addr_d  = ireq.addr;
          end else if (hit) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = ireq.addr[2] ? rd_word[63:32] : rd_word[31:0];
          end else begin
            state_d = S_REFILL;
            addr_d  = ireq.addr & LINE_MASK;
            cnt_d   = '0;
          end
        end
      end
      S_REFILL: begin
        creq.valid = 1'b1;
        creq.size  = MSIZE8;
        creq.addr  = addr_q;
        creq.len   = mlen_t'(WORDS_PER_LINE - 1);
        creq.burst = BURST_INCR;
        if (cresp.ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cresp.last) begin
            wr_en   = 1'b1;
            clr     = fpend_q | flush;
            fpend_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_UNCACHED: begin
        creq.valid = 1'b1;
        creq.size  = MSIZE4;
        creq.addr  = addr_q;
        creq.len   = MLEN1;
        creq.burst = BURST_INCR;
        if (cresp.ready && cresp.last) begin
          udata_d = addr_q[2] ? cresp.data[63:32] : cresp.data[31:0];
          upend_d = 1'b1;
          clr     = fpend_q | flush;
          fpend_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fpend_q <= 1'b0;
      upend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fpend_q <= fpend_d;
      upend_q <= upend_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    udata_q <= udata_d;
    if (state_q == S_REFILL && cresp.ready) begin
      linebuf_q[cnt_q] <= cresp.data;
    end
  end

`ifndef SYNTHESIS
  // A short burst still completes the fill; it signals a misbehaving bus.
  a_full_burst: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_REFILL && cresp.ready && cresp.last) |-> (cnt_q == CNT_W'(WORDS_PER_LINE - 1)))
    else $error("icache: refill burst ended early");
`endif

endmodule
